// File: rtl/mux_arb_pkg.sv
// Shared types and the rotating priority search for the 8:1 mux arbiter.
// rr_pick returns {found, index}; the search starts at ptr and wraps modulo 8.
package mux_arb_pkg;

    localparam int N_REQ = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    function automatic logic [SEL_W:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [SEL_W-1:0] ptr);
        logic [SEL_W:0]   res;
        logic [SEL_W-1:0] idx;
        res = '0;
        // Walk from the farthest offset back to ptr so the nearest requester wins.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = ptr + SEL_W'(i);
            if (req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mux8to1.sv
// Combinational 8:1 single-bit selector; select is {x,y,z} with x as MSB.
module mux8to1 (
    input  logic d0,
    input  logic d1,
    input  logic d2,
    input  logic d3,
    input  logic d4,
    input  logic d5,
    input  logic d6,
    input  logic d7,
    input  logic x,
    input  logic y,
    input  logic z,
    output logic out
);

    logic [7:0] d_vec;

    assign d_vec = {d7, d6, d5, d4, d3, d2, d1, d0};
    assign out   = d_vec[{x, y, z}];

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that owns the 8:1 mux select and registers the selected bit.
// state | meaning: IDLE | no grant, sel holds last value ; GRANT | gnt/sel drive one requester
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] d,
    output logic [SEL_W-1:0] sel,
    output logic [N_REQ-1:0] gnt,
    output logic             busy,
    output logic             out
);

    localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

    arb_state_t       state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_q, out_d;

    logic             rel;
    logic [SEL_W-1:0] arb_ptr;
    logic [SEL_W:0]   pick;
    logic             busy_d;
    logic             mux_out;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;

        rel     = (state_q == GRANT) && (!req[sel_q] || (cnt_q == CNT_LAST));
        // On release the search restarts just past the outgoing holder.
        arb_ptr = rel ? (sel_q + SEL_W'(1)) : ptr_q;
        pick    = rr_pick(req, arb_ptr);

        if ((state_q == IDLE) || rel) begin
            ptr_d = arb_ptr;
            if (pick[SEL_W]) begin
                state_d = GRANT;
                sel_d   = pick[SEL_W-1:0];
                gnt_d   = N_REQ'(1) << pick[SEL_W-1:0];
                cnt_d   = '0;
            end else begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        busy_d = (state_d == GRANT);
        out_d  = busy_d & mux_out;
    end

    mux8to1 u_mux (
        .d0  (d[0]),
        .d1  (d[1]),
        .d2  (d[2]),
        .d3  (d[3]),
        .d4  (d[4]),
        .d5  (d[5]),
        .d6  (d[6]),
        .d7  (d[7]),
        .x   (sel_d[2]),
        .y   (sel_d[1]),
        .z   (sel_d[0]),
        .out (mux_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            gnt_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            out_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    assign sel  = sel_q;
    assign gnt  = gnt_q;
    assign busy = (state_q == GRANT);
    assign out  = out_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter: a grant-length reference model feeds an
// expectation queue that a separate monitor drains one entry per clock.
module tb_mux_rr_arbiter;

    localparam int MH = 4;

    typedef struct {
        logic [7:0] gnt;
        logic [2:0] sel;
        logic       busy;
        logic       out;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] d;
    logic [2:0] sel;
    logic [7:0] gnt;
    logic       busy;
    logic       out;

    int checks = 0;
    int errors = 0;

    exp_t exp_q[$];

    // Reference model: who holds the grant and for how many cycles so far.
    bit m_busy;
    int m_sel;
    int m_ptr;
    int m_len;

    mux_rr_arbiter #(.MAX_HOLD(MH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .d     (d),
        .sel   (sel),
        .gnt   (gnt),
        .busy  (busy),
        .out   (out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    function automatic void model_reset();
        m_busy = 1'b0;
        m_sel  = 0;
        m_ptr  = 0;
        m_len  = 0;
    endfunction

    function automatic void model_grant(input logic [7:0] r);
        for (int o = 0; o < 8; o++) begin
            if (r[(m_ptr + o) % 8]) begin
                m_busy = 1'b1;
                m_sel  = (m_ptr + o) % 8;
                m_len  = 1;
                return;
            end
        end
        m_busy = 1'b0;
    endfunction

    function automatic void model_step(input logic [7:0] r);
        if (m_busy) begin
            if (!r[m_sel] || (m_len == MH)) begin
                m_ptr = (m_sel + 1) % 8;
                model_grant(r);
            end else begin
                m_len++;
            end
        end else begin
            model_grant(r);
        end
    endfunction

    task automatic drive(input logic [7:0] r, input logic [7:0] dv);
        exp_t e;
        @(negedge clk);
        req = r;
        d   = dv;
        model_step(r);
        e.gnt  = m_busy ? 8'(1 << m_sel) : 8'h00;
        e.sel  = 3'(m_sel);
        e.busy = m_busy;
        e.out  = m_busy ? dv[m_sel] : 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic tick(input logic [7:0] r, input logic [7:0] dv);
        drive(r, dv);
        @(posedge clk);
        #2;
    endtask

    task automatic check_now(input string name, input logic [7:0] g, input logic [2:0] s,
                             input logic b, input logic o);
        checks++;
        if (gnt !== g || sel !== s || busy !== b || out !== o) begin
            errors++;
            $display("FAIL %s: got gnt=%h sel=%0d busy=%b out=%b, required gnt=%h sel=%0d busy=%b out=%b",
                     name, gnt, sel, busy, out, g, s, b, o);
        end
    endtask

    // Monitor: compares the DUT against the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (gnt !== e.gnt || sel !== e.sel || busy !== e.busy || out !== e.out) begin
                    errors++;
                    $display("FAIL scoreboard @%0t: got gnt=%h sel=%0d busy=%b out=%b, required gnt=%h sel=%0d busy=%b out=%b",
                             $time, gnt, sel, busy, out, e.gnt, e.sel, e.busy, e.out);
                end
            end
        end
    end

    initial begin
        logic [7:0] dpat;
        logic [7:0] r;
        int         idx;

        dpat = 8'h96;
        model_reset();
        rst_n = 1'b0;
        req   = 8'hFF;
        d     = 8'hFF;

        repeat (3) begin
            @(posedge clk);
            #2;
            check_now("reset_hold", 8'h00, 3'd0, 1'b0, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        req   = 8'h00;

        // Sole requester 4: grant after one edge, re-wins at the hold limit.
        tick(8'h10, dpat);
        check_now("single_grant", 8'h10, 3'd4, 1'b1, 1'b1);
        for (int c = 0; c < 6; c++) begin
            tick(8'h10, dpat);
            check_now("single_rewin", 8'h10, 3'd4, 1'b1, 1'b1);
        end

        // Early release: 2 granted, then drops while 5 requests.
        tick(8'h04, dpat);
        check_now("grant_two", 8'h04, 3'd2, 1'b1, 1'b1);
        tick(8'h20, dpat);
        check_now("early_release", 8'h20, 3'd5, 1'b1, 1'b0);
        repeat (3) tick(8'h20, dpat);
        check_now("cnt_restart", 8'h20, 3'd5, 1'b1, 1'b0);

        // Idle return keeps sel and ptr; next full request grants 6.
        tick(8'h00, dpat);
        check_now("idle_return", 8'h00, 3'd5, 1'b0, 1'b0);
        tick(8'hFF, dpat);
        check_now("post_idle_grant", 8'h40, 3'd6, 1'b1, 1'b0);

        // Full rotation with data sweep: each requester exactly MH cycles.
        for (int c = 1; c <= 8 * MH; c++) begin
            tick(8'hFF, dpat);
            idx = (6 + c / MH) % 8;
            check_now("rotation", 8'(1 << idx), 3'(idx), 1'b1, dpat[idx]);
        end

        // Asynchronous reset mid-grant.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_now("async_reset", 8'h00, 3'd0, 1'b0, 1'b0);
        model_reset();
        repeat (2) begin
            @(posedge clk);
            #2;
            check_now("reset_hold2", 8'h00, 3'd0, 1'b0, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        tick(8'h0C, 8'h08);
        check_now("post_reset_ptr", 8'h04, 3'd2, 1'b1, 1'b0);

        // Randomized traffic with requests that tend to persist.
        r = 8'h0C;
        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 7))
                0:       r = 8'h00;
                1, 2:    r = 8'($urandom);
                3:       r = r ^ (8'h01 << $urandom_range(0, 7));
                4:       r = 8'h01 << $urandom_range(0, 7);
                default: r = r;
            endcase
            drive(r, 8'($urandom));
        end

        for (int w = 0; w < 5 && exp_q.size() > 0; w++) begin
            @(posedge clk);
            #2;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
